placement_cost_eval: RTL

//  Downstream stage of the random placer. After placement fills the X/Y position RAMs, this block

---
 rtl/placement_pkg.sv | 35 +++
 rtl/manhattan_axis.sv | 27 ++
 rtl/placement_cost_eval.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/placement_pkg.sv
// ---------------------------------------------------------------------------
// placement_pkg
// Shared definitions for the placement cost evaluator:
//   - FSM state encoding (S_IDLE .. S_DONE)
//   - UNPLACED marker written into the position RAMs for nodes never placed
//   - default data width
//   - in_grid(): coordinate validity test against a square GRID_N x GRID_N grid
// ---------------------------------------------------------------------------
package placement_pkg;

   localparam int DATA_W_DEFAULT = 32;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_EDGE   = 4'd1;
   localparam logic [3:0] S_EDGE_W = 4'd2;
   localparam logic [3:0] S_PA     = 4'd3;
   localparam logic [3:0] S_PA_W   = 4'd4;
   localparam logic [3:0] S_PB     = 4'd5;
   localparam logic [3:0] S_PB_W   = 4'd6;
   localparam logic [3:0] S_DIFF   = 4'd7;
   localparam logic [3:0] S_ACC    = 4'd8;
   localparam logic [3:0] S_DONE   = 4'd9;

   localparam int UNPLACED = -1;

   // Coordinates arrive sign-extended to 64 bits so the same test serves any
   // data width up to 64. UNPLACED is negative and would fail the range test
   // anyway; it is named explicitly so the intent stays visible.
   function automatic logic in_grid(input logic signed [63:0] coord, input int grid_n);
      logic signed [63:0] limit;
      limit = 64'(grid_n);
      return (coord != 64'(UNPLACED)) && (coord >= 0) && (coord < limit);
   endfunction

endpackage

// File: rtl/manhattan_axis.sv
// ---------------------------------------------------------------------------
// manhattan_axis
// Combinational distance along one axis.
//   a, b : coordinates (two's complement, W bits)
//   d    : |a - b|
//   h    : ceil(d / 2) = (d >> 1) + d[0], the one-hop distance
// ---------------------------------------------------------------------------
module manhattan_axis
   import placement_pkg::*;
#(
   parameter int W = DATA_W_DEFAULT
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] d,
   output logic [W-1:0] h
);

   logic [W-1:0] diff;

   always_comb begin
      diff = a - b;
      d    = diff[W-1] ? (~diff + {{(W-1){1'b0}}, 1'b1}) : diff;
      h    = (d >> 1) + {{(W-1){1'b0}}, d[0]};
   end

endmodule

// File: rtl/placement_cost_eval.sv
// ---------------------------------------------------------------------------
// placement_cost_eval
// Walks the edge list, fetches both endpoint positions and accumulates the
// Manhattan wirelength cost and the one-hop cost. Flags unplaced or
// out-of-grid nodes.
//
// Optional feature macro: COST_MAX_EDGE_EN adds the max_len output (largest
// dx+dy seen during the run).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   start      one-cycle request, honoured only in S_IDLE
//   busy       high from the cycle after start is accepted through S_DONE
//   done       one-cycle pulse in S_DONE
//   err        valid with done: an unplaced / out-of-grid node was seen
//   cost       sum of (dx+dy-1), held until next start
//   cost_1hop  sum of (ceil(dx/2)+ceil(dy/2)-1), held until next start
//   re_edge    read enable of edge ROMs A/B
//   addr_edge  edge index
//   dout_ea    node A of edge (from ROM A)
//   dout_eb    node B of edge (from ROM B)
//   re_pos     read enable of position RAMs X/Y
//   addr_pos   node index
//   dout_px    X coordinate (signed)
//   dout_py    Y coordinate (signed)
//   max_len    (COST_MAX_EDGE_EN only) largest dx+dy, valid with done
// ---------------------------------------------------------------------------
module placement_cost_eval
   import placement_pkg::*;
#(
   parameter int N_EDGE = 60,
   parameter int GRID_N = 7,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] cost,
   output logic [DATA_W-1:0] cost_1hop,
   output logic              re_edge,
   output logic [DATA_W-1:0] addr_edge,
   input  logic [DATA_W-1:0] dout_ea,
   input  logic [DATA_W-1:0] dout_eb,
   output logic              re_pos,
   output logic [DATA_W-1:0] addr_pos,
   input  logic [DATA_W-1:0] dout_px,
   input  logic [DATA_W-1:0] dout_py
`ifdef COST_MAX_EDGE_EN
   ,
   output logic [DATA_W-1:0] max_len
`endif
);

   localparam logic [DATA_W-1:0] ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] LAST_I = DATA_W'(N_EDGE - 1);

   logic [3:0]        state, state_next;
   logic [DATA_W-1:0] i, nb, xa, ya, dx, dy, hx, hy;
   logic [DATA_W-1:0] dx_c, dy_c, hx_c, hy_c;
   logic signed [63:0] px_ext, py_ext;
   logic              pos_ok;

   // The position RAM output carries node A's coordinates in S_PB and node B's
   // in S_DIFF, so one validity check covers both endpoints.
   always_comb begin
      px_ext = 64'($signed(dout_px));
      py_ext = 64'($signed(dout_py));
      pos_ok = in_grid(px_ext, GRID_N) && in_grid(py_ext, GRID_N);
   end

   manhattan_axis #(.W(DATA_W)) u_axis_x (.a(xa), .b(dout_px), .d(dx_c), .h(hx_c));
   manhattan_axis #(.W(DATA_W)) u_axis_y (.a(ya), .b(dout_py), .d(dy_c), .h(hy_c));

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = (N_EDGE == 0) ? S_DONE : S_EDGE;
         S_EDGE:   state_next = S_EDGE_W;
         S_EDGE_W: state_next = S_PA;
         S_PA:     state_next = S_PA_W;
         S_PA_W:   state_next = S_PB;
         S_PB:     state_next = pos_ok ? S_PB_W : S_DONE;
         S_PB_W:   state_next = S_DIFF;
         S_DIFF:   state_next = pos_ok ? S_ACC : S_DONE;
         S_ACC:    state_next = (i == LAST_I) ? S_DONE : S_EDGE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // busy/done are decoded from the next state so they line up with the state
   // itself; the read strobes are decoded from the current state, so a read
   // requested in state S reaches the memory one cycle later and its data is
   // back two states after S.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cost      <= '0;
         cost_1hop <= '0;
         re_edge   <= 1'b0;
         addr_edge <= '0;
         re_pos    <= 1'b0;
         addr_pos  <= '0;
         i         <= '0;
         nb        <= '0;
         xa        <= '0;
         ya        <= '0;
         dx        <= '0;
         dy        <= '0;
         hx        <= '0;
         hy        <= '0;
`ifdef COST_MAX_EDGE_EN
         max_len   <= '0;
`endif
      end else begin
         state   <= state_next;
         busy    <= (state_next != S_IDLE);
         done    <= (state_next == S_DONE);
         re_edge <= (state == S_EDGE);
         re_pos  <= (state == S_PA) || (state == S_PB);
         case (state)
            S_IDLE: begin
               if (start) begin
                  cost      <= '0;
                  cost_1hop <= '0;
                  err       <= 1'b0;
                  i         <= '0;
`ifdef COST_MAX_EDGE_EN
                  max_len   <= '0;
`endif
               end
            end
            S_EDGE: addr_edge <= i;
            S_PA: begin
               nb       <= dout_eb;
               addr_pos <= dout_ea;
            end
            S_PB: begin
               xa       <= dout_px;
               ya       <= dout_py;
               addr_pos <= nb;
               if (!pos_ok) err <= 1'b1;
            end
            S_DIFF: begin
               dx <= dx_c;
               dy <= dy_c;
               hx <= hx_c;
               hy <= hy_c;
               if (!pos_ok) err <= 1'b1;
            end
            S_ACC: begin
               cost      <= cost + dx + dy - ONE;
               cost_1hop <= cost_1hop + hx + hy - ONE;
               i         <= i + ONE;
`ifdef COST_MAX_EDGE_EN
               if ((dx + dy) > max_len) max_len <= dx + dy;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
